// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe controller: state codes, line geometry
// and the bot's corner preference order.
package ttt_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_CHK  = 3'd2;
    localparam logic [2:0] ST_BOT  = 3'd3;
    localparam logic [2:0] ST_OVER = 3'd4;

    localparam int unsigned NUM_CORNERS = 4;

    // Lines 0..n-1 are rows, n..2n-1 columns, 2n the main diagonal, 2n+1 the anti-diagonal.
    function automatic int unsigned line_cell(input int unsigned n, input int unsigned l,
                                              input int unsigned k);
        if (l < n)
            return l * n + k;
        else if (l < 2 * n)
            return k * n + (l - n);
        else if (l == 2 * n)
            return k * n + k;
        else
            return k * n + (n - 1 - k);
    endfunction

    function automatic int unsigned corner_cell(input int unsigned n, input int unsigned c);
        case (c)
            0:       return n * n - 1;
            1:       return 0;
            2:       return n - 1;
            default: return n * (n - 1);
        endcase
    endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Player/host port of the tic-tac-toe controller: move handshake, game control
// and LED board outputs.
interface ttt_game_ctrl_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned NN   = N * N;
    localparam int unsigned IDXW = $clog2(NN);

    logic            start;
    logic            bot_en;
    logic            bot_first;
    logic            move_valid;
    logic [IDXW-1:0] move_idx;
    logic            move_ready;
    logic            move_illegal;
    logic            turn;
    logic [NN-1:0]   board_r;
    logic [NN-1:0]   board_g;
    logic            bot_move_valid;
    logic [IDXW-1:0] bot_move_idx;
    logic            rw;
    logic            gw;
    logic            draw;
    logic            over;

    modport master (
        output start, bot_en, bot_first, move_valid, move_idx,
        input  move_ready, move_illegal, turn, board_r, board_g,
               bot_move_valid, bot_move_idx, rw, gw, draw, over
    );

    modport slave (
        input  start, bot_en, bot_first, move_valid, move_idx,
        output move_ready, move_illegal, turn, board_r, board_g,
               bot_move_valid, bot_move_idx, rw, gw, draw, over
    );

endinterface

// File: rtl/ttt_bot_pick.sv
// Combinational bot move choice: win > block > centre > corner > lowest free cell.
module ttt_bot_pick
    import ttt_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N*N-1:0]         board_r,
    input  logic [N*N-1:0]         board_g,
    output logic [$clog2(N*N)-1:0] pick_idx,
    output logic                   pick_valid
);
    localparam int unsigned NN   = N * N;
    localparam int unsigned IDXW = $clog2(NN);
    localparam logic [IDXW-1:0] CENTRE_IDX = IDXW'((NN - 1) / 2);

    logic [NN-1:0]   empty;
    logic [NN-1:0]   win_m;
    logic [NN-1:0]   blk_m;
    logic [IDXW-1:0] c;
    int unsigned     cnt_r;
    int unsigned     cnt_g;
    logic            found;

    assign empty      = ~(board_r | board_g);
    assign pick_valid = |empty;

    // A line with N-1 own pieces and nothing of the opponent has exactly one empty cell.
    always_comb begin
        win_m = '0;
        blk_m = '0;
        c     = '0;
        cnt_r = 0;
        cnt_g = 0;
        for (int unsigned l = 0; l < 2 * N + 2; l++) begin
            cnt_r = 0;
            cnt_g = 0;
            for (int unsigned k = 0; k < N; k++) begin
                c = IDXW'(line_cell(N, l, k));
                if (board_r[c]) cnt_r++;
                if (board_g[c]) cnt_g++;
            end
            for (int unsigned k = 0; k < N; k++) begin
                c = IDXW'(line_cell(N, l, k));
                if (cnt_g == N - 1 && cnt_r == 0) win_m[c] = win_m[c] | empty[c];
                if (cnt_r == N - 1 && cnt_g == 0) blk_m[c] = blk_m[c] | empty[c];
            end
        end
    end

    always_comb begin
        pick_idx = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NN; i++) begin
            if (!found && win_m[i]) begin
                pick_idx = IDXW'(i);
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NN; i++) begin
            if (!found && blk_m[i]) begin
                pick_idx = IDXW'(i);
                found    = 1'b1;
            end
        end
        if (!found && (N % 2 == 1) && empty[CENTRE_IDX]) begin
            pick_idx = CENTRE_IDX;
            found    = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_CORNERS; i++) begin
            if (!found && empty[IDXW'(corner_cell(N, i))]) begin
                pick_idx = IDXW'(corner_cell(N, i));
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NN; i++) begin
            if (!found && empty[i]) begin
                pick_idx = IDXW'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: owns the board, accepts human moves, runs the
// bot, and flags win/draw.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic           clk,
    input  logic           rs,
    ttt_game_ctrl_if.slave gif
);
    localparam int unsigned NN   = N * N;
    localparam int unsigned IDXW = $clog2(NN);

    logic [2:0]      state_q, state_d;
    logic [NN-1:0]   board_r_q, board_r_d;
    logic [NN-1:0]   board_g_q, board_g_d;
    logic            turn_q, turn_d;
    logic            rw_q, rw_d;
    logic            gw_q, gw_d;
    logic            draw_q, draw_d;
    logic            over_q, over_d;
    logic            illegal_q, illegal_d;
    logic            bot_valid_q, bot_valid_d;
    logic [IDXW-1:0] bot_idx_q, bot_idx_d;
    logic            bot_en_q, bot_en_d;

    logic [IDXW-1:0] pick_idx;
    logic            pick_valid;
    logic [NN-1:0]   move_oh;
    logic            move_legal;
    logic            r_win, g_win, all_r, all_g;
    logic [IDXW-1:0] c;
    logic            full;

    ttt_bot_pick #(.N(N)) u_pick (
        .board_r    (board_r_q),
        .board_g    (board_g_q),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // Out-of-range indices shift the one-hot to zero, so the range test must gate legality.
    assign move_oh    = NN'(1) << gif.move_idx;
    assign move_legal = ({1'b0, gif.move_idx} < (IDXW + 1)'(NN))
                        && (((board_r_q | board_g_q) & move_oh) == '0);
    assign full       = &(board_r_q | board_g_q);

    always_comb begin
        r_win = 1'b0;
        g_win = 1'b0;
        all_r = 1'b0;
        all_g = 1'b0;
        c     = '0;
        for (int unsigned l = 0; l < 2 * N + 2; l++) begin
            all_r = 1'b1;
            all_g = 1'b1;
            for (int unsigned k = 0; k < N; k++) begin
                c     = IDXW'(line_cell(N, l, k));
                all_r = all_r & board_r_q[c];
                all_g = all_g & board_g_q[c];
            end
            r_win = r_win | all_r;
            g_win = g_win | all_g;
        end
    end

    always_comb begin
        state_d     = state_q;
        board_r_d   = board_r_q;
        board_g_d   = board_g_q;
        turn_d      = turn_q;
        rw_d        = rw_q;
        gw_d        = gw_q;
        draw_d      = draw_q;
        over_d      = over_q;
        illegal_d   = 1'b0;
        bot_valid_d = 1'b0;
        bot_idx_d   = bot_idx_q;
        bot_en_d    = bot_en_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (gif.start) begin
                    board_r_d = '0;
                    board_g_d = '0;
                    rw_d      = 1'b0;
                    gw_d      = 1'b0;
                    draw_d    = 1'b0;
                    over_d    = 1'b0;
                    bot_en_d  = gif.bot_en;
                    if (gif.bot_en && gif.bot_first) begin
                        state_d = ST_BOT;
                        turn_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        turn_d  = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (gif.move_valid) begin
                    if (move_legal) begin
                        if (turn_q) board_g_d = board_g_q | move_oh;
                        else        board_r_d = board_r_q | move_oh;
                        state_d = ST_CHK;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_CHK: begin
                if (r_win || g_win) begin
                    rw_d    = r_win;
                    gw_d    = g_win;
                    over_d  = 1'b1;
                    state_d = ST_OVER;
                end else if (full) begin
                    draw_d  = 1'b1;
                    over_d  = 1'b1;
                    state_d = ST_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = (bot_en_q && !turn_q) ? ST_BOT : ST_WAIT;
                end
            end
            ST_BOT: begin
                if (pick_valid) begin
                    board_g_d   = board_g_q | (NN'(1) << pick_idx);
                    bot_idx_d   = pick_idx;
                    bot_valid_d = 1'b1;
                end
                state_d = ST_CHK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            state_q     <= ST_IDLE;
            board_r_q   <= '0;
            board_g_q   <= '0;
            turn_q      <= 1'b0;
            rw_q        <= 1'b0;
            gw_q        <= 1'b0;
            draw_q      <= 1'b0;
            over_q      <= 1'b0;
            illegal_q   <= 1'b0;
            bot_valid_q <= 1'b0;
            bot_idx_q   <= '0;
            bot_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_r_q   <= board_r_d;
            board_g_q   <= board_g_d;
            turn_q      <= turn_d;
            rw_q        <= rw_d;
            gw_q        <= gw_d;
            draw_q      <= draw_d;
            over_q      <= over_d;
            illegal_q   <= illegal_d;
            bot_valid_q <= bot_valid_d;
            bot_idx_q   <= bot_idx_d;
            bot_en_q    <= bot_en_d;
        end
    end

    assign gif.move_ready     = (state_q == ST_WAIT);
    assign gif.move_illegal   = illegal_q;
    assign gif.turn           = turn_q;
    assign gif.board_r        = board_r_q;
    assign gif.board_g        = board_g_q;
    assign gif.bot_move_valid = bot_valid_q;
    assign gif.bot_move_idx   = bot_idx_q;
    assign gif.rw             = rw_q;
    assign gif.gw             = gw_q;
    assign gif.draw           = draw_q;
    assign gif.over           = over_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl (N=3): reset, bot play, illegal moves, draw, restart.
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        rs;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    ttt_game_ctrl_if #(.N(3)) gif();

    ttt_game_ctrl #(.N(3)) dut (
        .clk (clk),
        .rs  (rs),
        .gif (gif)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic play(input int unsigned idx);
        gif.move_valid = 1'b1;
        gif.move_idx   = 4'(idx);
        tick();
        gif.move_valid = 1'b0;
    endtask

    task automatic new_game(input logic be, input logic bf);
        gif.start     = 1'b1;
        gif.bot_en    = be;
        gif.bot_first = bf;
        tick();
        gif.start = 1'b0;
    endtask

    task automatic do_reset();
        rs = 1'b1;
        tick();
        tick();
        rs = 1'b0;
    endtask

    int unsigned seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        // Reset held with start and move_valid asserted
        rs             = 1'b1;
        gif.start      = 1'b1;
        gif.bot_en     = 1'b1;
        gif.bot_first  = 1'b1;
        gif.move_valid = 1'b1;
        gif.move_idx   = '0;
        tick();
        tick();
        check_eq("rst_board_r", 32'(gif.board_r), 32'h0);
        check_eq("rst_board_g", 32'(gif.board_g), 32'h0);
        check_eq("rst_turn", 32'(gif.turn), 32'h0);
        check_eq("rst_flags", 32'({gif.rw, gif.gw, gif.draw, gif.over}), 32'h0);
        check_eq("rst_ready", 32'(gif.move_ready), 32'h0);
        check_eq("rst_pulses", 32'({gif.move_illegal, gif.bot_move_valid}), 32'h0);
        check_eq("rst_bot_idx", 32'(gif.bot_move_idx), 32'h0);
        rs             = 1'b0;
        gif.start      = 1'b0;
        gif.move_valid = 1'b0;

        // Bot moves first: centre
        new_game(1'b1, 1'b1);
        check_eq("bf_turn_bot", 32'(gif.turn), 32'h1);
        check_eq("bf_ready0", 32'(gif.move_ready), 32'h0);
        tick();
        check_eq("bf_bot_valid", 32'(gif.bot_move_valid), 32'h1);
        check_eq("bf_bot_idx", 32'(gif.bot_move_idx), 32'h4);
        check_eq("bf_board_g", 32'(gif.board_g), 32'h010);
        tick();
        check_eq("bf_bot_pulse_end", 32'(gif.bot_move_valid), 32'h0);
        check_eq("bf_turn_human", 32'(gif.turn), 32'h0);
        check_eq("bf_ready1", 32'(gif.move_ready), 32'h1);

        // Human first against the bot: corner, block, win
        do_reset();
        new_game(1'b1, 1'b0);
        check_eq("hf_ready", 32'(gif.move_ready), 32'h1);
        play(4);
        check_eq("hf_r4", 32'(gif.board_r), 32'h010);
        check_eq("hf_ready_chk", 32'(gif.move_ready), 32'h0);
        tick();
        check_eq("hf_turn_g", 32'(gif.turn), 32'h1);
        tick();
        check_eq("hf_bot8_valid", 32'(gif.bot_move_valid), 32'h1);
        check_eq("hf_bot8_idx", 32'(gif.bot_move_idx), 32'h8);
        check_eq("hf_bot8_board", 32'(gif.board_g), 32'h100);
        tick();
        play(2);
        check_eq("hf_r2", 32'(gif.board_r), 32'h014);
        tick();
        tick();
        check_eq("hf_block6_idx", 32'(gif.bot_move_idx), 32'h6);
        check_eq("hf_block6_board", 32'(gif.board_g), 32'h140);
        tick();
        play(3);
        tick();
        tick();
        check_eq("hf_win7_idx", 32'(gif.bot_move_idx), 32'h7);
        check_eq("hf_win7_board", 32'(gif.board_g), 32'h1C0);
        check_eq("hf_over_pending", 32'(gif.over), 32'h0);
        tick();
        check_eq("hf_gw", 32'(gif.gw), 32'h1);
        check_eq("hf_rw", 32'(gif.rw), 32'h0);
        check_eq("hf_over", 32'(gif.over), 32'h1);
        check_eq("hf_draw", 32'(gif.draw), 32'h0);
        check_eq("over_ready", 32'(gif.move_ready), 32'h0);

        // Moves ignored in OVER
        play(0);
        check_eq("over_no_illegal", 32'(gif.move_illegal), 32'h0);
        check_eq("over_board_r_held", 32'(gif.board_r), 32'h01C);
        check_eq("over_gw_held", 32'(gif.gw), 32'h1);

        // Restart from OVER, then illegal moves
        new_game(1'b1, 1'b0);
        check_eq("rs_board_r", 32'(gif.board_r), 32'h0);
        check_eq("rs_board_g", 32'(gif.board_g), 32'h0);
        check_eq("rs_flags", 32'({gif.rw, gif.gw, gif.draw, gif.over}), 32'h0);
        check_eq("rs_ready", 32'(gif.move_ready), 32'h1);
        play(0);
        tick();
        tick();
        check_eq("il_bot_centre", 32'(gif.bot_move_idx), 32'h4);
        tick();
        play(4);
        check_eq("il_occ_pulse", 32'(gif.move_illegal), 32'h1);
        check_eq("il_occ_board_r", 32'(gif.board_r), 32'h001);
        check_eq("il_occ_board_g", 32'(gif.board_g), 32'h010);
        check_eq("il_occ_ready", 32'(gif.move_ready), 32'h1);
        check_eq("il_occ_turn", 32'(gif.turn), 32'h0);
        tick();
        check_eq("il_pulse_end", 32'(gif.move_illegal), 32'h0);
        play(9);
        check_eq("il_range_pulse", 32'(gif.move_illegal), 32'h1);
        check_eq("il_range_board_r", 32'(gif.board_r), 32'h001);
        check_eq("il_range_ready", 32'(gif.move_ready), 32'h1);
        tick();
        play(1);
        check_eq("il_ok_no_pulse", 32'(gif.move_illegal), 32'h0);
        check_eq("il_ok_board_r", 32'(gif.board_r), 32'h003);
        tick();
        tick();
        check_eq("il_bot_block2", 32'(gif.bot_move_idx), 32'h2);
        tick();

        // Two-player draw
        do_reset();
        new_game(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("tp_turn%0d", i), 32'(gif.turn), 32'(i % 2));
            play(seq[i]);
            tick();
        end
        check_eq("tp_board_r", 32'(gif.board_r), 32'h18D);
        check_eq("tp_board_g", 32'(gif.board_g), 32'h072);
        check_eq("tp_draw", 32'(gif.draw), 32'h1);
        check_eq("tp_wins", 32'({gif.rw, gif.gw}), 32'h0);
        check_eq("tp_over", 32'(gif.over), 32'h1);
        check_eq("tp_no_bot", 32'(gif.bot_move_valid), 32'h0);

        // Reset during a BOT cycle
        new_game(1'b1, 1'b1);
        rs = 1'b1;
        tick();
        rs = 1'b0;
        check_eq("rb_board_g", 32'(gif.board_g), 32'h0);
        check_eq("rb_bot_valid", 32'(gif.bot_move_valid), 32'h0);
        check_eq("rb_bot_idx", 32'(gif.bot_move_idx), 32'h0);
        check_eq("rb_turn", 32'(gif.turn), 32'h0);
        check_eq("rb_ready", 32'(gif.move_ready), 32'h0);
        tick();
        check_eq("rb_stays_idle", 32'({gif.move_ready, gif.board_g != 9'h0}), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
